// File: rtl/stream_mux_n.sv
// N-to-1 valid/ready stream mux with static or round-robin arbitration,
// packet locking on in_last and a one-deep registered output.
module stream_mux_n #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SW    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SW-1:0]      out_ch
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SW-1:0]    r_lock_ch;
  logic             r_lock_rr;
  logic [SW-1:0]    r_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SW-1:0]    r_out_ch;

  logic [SW-1:0]    w_grant;
  logic             w_grant_ok;
  logic             w_slot_free;
  logic             w_gvalid;
  logic             w_glast;
  logic [WIDTH-1:0] w_gdata;
  logic             w_accept;
  logic             w_rr;
  logic [SW-1:0]    w_ptr_nxt;
  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  int               w_off;
  int               w_sum;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_accept    = w_slot_free && w_grant_ok && w_gvalid;
  // A locked packet keeps the arbitration mode it started with
  assign w_rr        = (r_state == S_LOCKED) ? r_lock_rr : mode;
  assign w_ptr_nxt   = (w_grant == SW'(N-1)) ? '0 : w_grant + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_glast) w_state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        if (w_accept && w_glast) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant    = '0;
    w_grant_ok = 1'b0;
    w_dbl      = {in_valid, in_valid} >> r_ptr;
    w_rot      = w_dbl[N-1:0];
    w_off      = 0;
    w_sum      = 0;
    case (r_state)
      S_LOCKED: begin
        w_grant    = r_lock_ch;
        w_grant_ok = 1'b1;
      end
      default: begin
        if (!mode) begin
          w_grant    = sel;
          w_grant_ok = (int'(sel) < N);
        end else begin
          for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = k;
          end
          w_sum = int'(r_ptr) + w_off;
          if (w_sum >= N) w_sum = w_sum - N;
          w_grant    = SW'(w_sum);
          w_grant_ok = |in_valid;
        end
      end
    endcase
  end

  always_comb begin
    w_gvalid = 1'b0;
    w_glast  = 1'b0;
    w_gdata  = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SW'(i)) begin
        w_gvalid    = in_valid[i];
        w_glast     = in_last[i];
        w_gdata     = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = rst_n && w_slot_free && w_grant_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
      r_lock_ch   <= '0;
      r_lock_rr   <= 1'b0;
      r_ptr       <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gdata;
        r_out_last  <= w_glast;
        r_out_ch    <= w_grant;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept && r_state == S_IDLE) begin
        r_lock_ch <= w_grant;
        r_lock_rr <= mode;
      end
      if (w_accept && w_glast && w_rr) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_ch    = r_out_ch;

endmodule
